// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch controller.
//   fetch_state_e        : fetch FSM state encoding
//   PC_INC               : sequential PC increment (one 32-bit word)
//   DEFAULT_RESET_VECTOR : first fetch address after reset
//   pc_next()            : sequential next-PC, wraps modulo 2^32
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StHold   = 2'd2,
    StHalted = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INC               = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Plain 32-bit add: 32'hFFFF_FFFC + 4 naturally wraps to 0.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/mips_fetch_ctrl_if.sv
// Bundle of the fetch controller's memory, decode and redirect signals.
//   master : fetch controller side (drives request, instruction and error outputs)
//   slave  : environment side (memory, decode and branch unit)
interface mips_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        halt;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, br_taken, br_target, jmp, jmp_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    output imem_ack, imem_rdata, instr_ready, br_taken, br_target, jmp, jmp_target, halt
  );
endinterface

// File: rtl/mips_pc_reg.sv
// Program-counter register.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset, loads RESET_VECTOR
//   i_load : load enable for i_d
//   i_d    : next PC value
//   o_q    : current PC
module mips_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= RESET_VECTOR;
    end else if (i_load) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/mips_fetch_ctrl.sv
// Instruction-fetch controller: issues one memory read at a time, holds the
// returned word for decode, and handles jump/branch redirects and halt.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   if_bus : mips_fetch_ctrl_if.master (memory request/ack, decode handshake,
//            redirect inputs, halt level, fetch-error pulse)
module mips_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  mips_fetch_ctrl_if.master        if_bus
);

  fetch_state_e r_state, w_state_d;

  logic [31:0] w_pc;
  logic        w_pc_load;
  logic [31:0] w_pc_d;

  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        w_instr_load;

  // Redirect seen while a request is outstanding; applied when it acks.
  logic        r_redir_vld, w_redir_vld_d;
  logic [31:0] r_redir_tgt, w_redir_tgt_d;
  // Misaligned redirect seen while a request is outstanding: halt on ack.
  logic        r_err_pend, w_err_pend_d;
  logic        r_fetch_err, w_fetch_err_d;

  logic        w_redir;
  logic [31:0] w_tgt;
  logic        w_tgt_bad;
  logic        w_tgt_ok;

  // JMP wins over BR_TAKEN when both pulse together.
  assign w_redir   = if_bus.jmp | if_bus.br_taken;
  assign w_tgt     = if_bus.jmp ? if_bus.jmp_target : if_bus.br_target;
  assign w_tgt_bad = w_redir & (w_tgt[1:0] != 2'b00);
  assign w_tgt_ok  = w_redir & (w_tgt[1:0] == 2'b00);

  mips_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_pc_load),
    .i_d    (w_pc_d),
    .o_q    (w_pc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_instr     <= 32'h0;
      r_instr_pc  <= 32'h0;
      r_redir_vld <= 1'b0;
      r_redir_tgt <= 32'h0;
      r_err_pend  <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_redir_vld <= w_redir_vld_d;
      r_redir_tgt <= w_redir_tgt_d;
      r_err_pend  <= w_err_pend_d;
      r_fetch_err <= w_fetch_err_d;
      if (w_instr_load) begin
        r_instr    <= if_bus.imem_rdata;
        r_instr_pc <= w_pc;
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_pc_load     = 1'b0;
    w_pc_d        = pc_next(w_pc);
    w_instr_load  = 1'b0;
    w_redir_vld_d = r_redir_vld;
    w_redir_tgt_d = r_redir_tgt;
    w_err_pend_d  = r_err_pend;
    w_fetch_err_d = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_tgt_bad) begin
          w_fetch_err_d = 1'b1;
          w_state_d     = StHalted;
        end else begin
          if (w_tgt_ok) begin
            w_pc_load = 1'b1;
            w_pc_d    = w_tgt;
          end
          w_state_d = if_bus.halt ? StHalted : StFetch;
        end
      end

      StFetch: begin
        if (w_tgt_bad && !r_err_pend) begin
          w_fetch_err_d = 1'b1;
        end
        if (if_bus.imem_ack) begin
          w_redir_vld_d = 1'b0;
          w_err_pend_d  = 1'b0;
          if (w_tgt_bad || r_err_pend) begin
            w_state_d = StHalted;
          end else if (w_tgt_ok) begin
            // Returned word is stale; refetch from the target straight away.
            w_pc_load = 1'b1;
            w_pc_d    = w_tgt;
          end else if (r_redir_vld) begin
            w_pc_load = 1'b1;
            w_pc_d    = r_redir_tgt;
          end else begin
            w_instr_load = 1'b1;
            w_state_d    = StHold;
          end
        end else if (w_tgt_bad) begin
          w_err_pend_d = 1'b1;
        end else if (w_tgt_ok) begin
          // Request stays up at the old address; only remember the target.
          w_redir_vld_d = 1'b1;
          w_redir_tgt_d = w_tgt;
        end
      end

      StHold: begin
        if (w_tgt_bad) begin
          w_fetch_err_d = 1'b1;
          w_state_d     = StHalted;
        end else if (w_tgt_ok || if_bus.instr_ready) begin
          // A redirect drops the held word; with READY it still counts as taken.
          w_pc_load = 1'b1;
          w_pc_d    = w_tgt_ok ? w_tgt : pc_next(w_pc);
          w_state_d = (if_bus.instr_ready && if_bus.halt) ? StHalted : StFetch;
        end
      end

      StHalted: begin
        w_state_d = StHalted;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign if_bus.imem_req    = (r_state == StFetch);
  assign if_bus.imem_addr   = w_pc;
  assign if_bus.instr_valid = (r_state == StHold);
  assign if_bus.instr       = r_instr;
  assign if_bus.instr_pc    = r_instr_pc;
  assign if_bus.fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_mips_fetch_ctrl.sv
// Directed bench for mips_fetch_ctrl: a per-cycle vector table followed by
// hand-written throughput and halt-during-fetch sequences.
module tb_mips_fetch_ctrl;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        br;
    logic [31:0] btgt;
    logic        jmp;
    logic [31:0] jtgt;
    logic        halt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        err;
  } vec_t;

  logic clk;
  logic rst;
  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  mips_fetch_ctrl_if u_if ();

  mips_fetch_ctrl u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .if_bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic add(input int r, input int ack, input logic [31:0] rd, input int rdy,
                     input int br, input logic [31:0] bt, input int jmp,
                     input logic [31:0] jt, input int halt, input int req,
                     input logic [31:0] addr, input int vld, input logic [31:0] ins,
                     input logic [31:0] ipc, input int err);
    vec_t v;
    v.rst = r[0];    v.ack = ack[0];  v.rdata = rd;  v.ready = rdy[0];
    v.br = br[0];    v.btgt = bt;     v.jmp = jmp[0]; v.jtgt = jt;  v.halt = halt[0];
    v.req = req[0];  v.addr = addr;   v.valid = vld[0];
    v.instr = ins;   v.ipc = ipc;     v.err = err[0];
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    u_if.imem_ack    = 1'b0;
    u_if.imem_rdata  = 32'h0;
    u_if.instr_ready = 1'b0;
    u_if.br_taken    = 1'b0;
    u_if.br_target   = 32'h0;
    u_if.jmp         = 1'b0;
    u_if.jmp_target  = 32'h0;
    u_if.halt        = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int          n_acc;
  logic [31:0] exp_pc;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive_idle();

    // rst ack rdata        rdy br bt          jmp jt           hlt | req addr          vld instr          ipc           err
    // Sequential fetch, ACK with REQ, then delayed ACK and decode stall.
    add(1, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 1, 'h1111_0000,  1,  0, 'h0,        0, 'h0,          0,  1, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h0,          1, 'h1111_0000,  'h0,          0);
    add(0, 1, 'h2222_0004,  0,  0, 'h0,        0, 'h0,          0,  1, 'h4,          0, 'h1111_0000,  'h0,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h4,          1, 'h2222_0004,  'h4,          0);
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h4,          1, 'h2222_0004,  'h4,          0);
    add(0, 0, 'hDEAD_BEEF,  1,  0, 'h0,        0, 'h0,          0,  1, 'h8,          0, 'h2222_0004,  'h4,          0);
    add(0, 0, 'hDEAD_BEEF,  1,  0, 'h0,        0, 'h0,          0,  1, 'h8,          0, 'h2222_0004,  'h4,          0);
    add(0, 0, 'hDEAD_BEEF,  1,  0, 'h0,        0, 'h0,          0,  1, 'h8,          0, 'h2222_0004,  'h4,          0);
    add(0, 1, 'h3333_0008,  0,  0, 'h0,        0, 'h0,          0,  1, 'h8,          0, 'h2222_0004,  'h4,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h8,          1, 'h3333_0008,  'h8,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h8,          1, 'h3333_0008,  'h8,          0);
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h8,          1, 'h3333_0008,  'h8,          0);
    add(0, 1, 'h4444_000C,  0,  0, 'h0,        0, 'h0,          0,  1, 'hC,          0, 'h3333_0008,  'h8,          0);
    // JMP and BR together in HOLD: JMP wins.
    add(0, 0, 'h0,          0,  1, 'h300,      1, 'h200,        0,  0, 'hC,          1, 'h4444_000C,  'hC,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  1, 'h200,        0, 'h4444_000C,  'hC,          0);
    add(0, 1, 'h5555_0200,  0,  0, 'h0,        0, 'h0,          0,  1, 'h200,        0, 'h4444_000C,  'hC,          0);
    // Redirect coincident with READY: next fetch at target.
    add(0, 0, 'h0,          1,  1, 'h400,      0, 'h0,          0,  0, 'h200,        1, 'h5555_0200,  'h200,        0);
    add(0, 1, 'h6666_0400,  0,  0, 'h0,        0, 'h0,          0,  1, 'h400,        0, 'h5555_0200,  'h200,        0);
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h400,        1, 'h6666_0400,  'h400,        0);
    // Reset mid-FETCH clears outputs at once; late ACK in IDLE ignored.
    add(1, 1, 'h7777_0404,  0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 1, 'hDEAD_0000,  0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 1, 'hA000_0000,  0,  0, 'h0,        0, 'h0,          0,  1, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h0,          1, 'hA000_0000,  'h0,          0);
    add(0, 1, 'hA000_0004,  0,  0, 'h0,        0, 'h0,          0,  1, 'h4,          0, 'hA000_0000,  'h0,          0);
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h4,          1, 'hA000_0004,  'h4,          0);
    // Branch to 0x100 during the pending fetch at 0x8: word from 0x8 discarded.
    add(0, 0, 'h0,          0,  1, 'h100,      0, 'h0,          0,  1, 'h8,          0, 'hA000_0004,  'h4,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  1, 'h8,          0, 'hA000_0004,  'h4,          0);
    add(0, 1, 'hBAD0_0008,  1,  0, 'h0,        0, 'h0,          0,  1, 'h8,          0, 'hA000_0004,  'h4,          0);
    add(0, 1, 'hB000_0100,  0,  0, 'h0,        0, 'h0,          0,  1, 'h100,        0, 'hA000_0004,  'h4,          0);
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h100,        1, 'hB000_0100,  'h100,        0);
    // Jump on the very ACK cycle.
    add(0, 1, 'hBAD0_0104,  0,  0, 'h0,        1, 'h180,        0,  1, 'h104,        0, 'hB000_0100,  'h100,        0);
    add(0, 1, 'hC000_0180,  0,  0, 'h0,        0, 'h0,          0,  1, 'h180,        0, 'hB000_0100,  'h100,        0);
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h180,        1, 'hC000_0180,  'h180,        0);
    // Newer pending redirect overwrites older.
    add(0, 0, 'h0,          0,  1, 'h500,      0, 'h0,          0,  1, 'h184,        0, 'hC000_0180,  'h180,        0);
    add(0, 0, 'h0,          0,  0, 'h0,        1, 'h600,        0,  1, 'h184,        0, 'hC000_0180,  'h180,        0);
    add(0, 1, 'hBAD0_0184,  0,  0, 'h0,        0, 'h0,          0,  1, 'h184,        0, 'hC000_0180,  'h180,        0);
    add(0, 1, 'hD000_0600,  0,  0, 'h0,        0, 'h0,          0,  1, 'h600,        0, 'hC000_0180,  'h180,        0);
    // HALT with accept: halted, redirects ignored, no further requests.
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          1,  0, 'h600,        1, 'hD000_0600,  'h600,        0);
    add(0, 1, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h604,        0, 'hD000_0600,  'h600,        0);
    add(0, 1, 'h0,          0,  0, 'h0,        1, 'h700,        0,  0, 'h604,        0, 'hD000_0600,  'h600,        0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h604,        0, 'hD000_0600,  'h600,        0);
    // Misaligned jump in HOLD: one-cycle FETCH_ERR, halted.
    add(1, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 1, 'hE000_0000,  0,  0, 'h0,        0, 'h0,          0,  1, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        1, 'h102,        0,  0, 'h0,          1, 'hE000_0000,  'h0,          0);
    add(0, 1, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'hE000_0000,  'h0,          1);
    add(0, 1, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'hE000_0000,  'h0,          0);
    add(0, 1, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'hE000_0000,  'h0,          0);
    // Misaligned branch with a request outstanding: halt only after its ACK.
    add(1, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          0,  1, 'h103,      0, 'h0,          0,  1, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  1, 'h0,          0, 'h0,          'h0,          1);
    add(0, 1, 'hBAD0_0000,  1,  0, 'h0,        0, 'h0,          0,  1, 'h0,          0, 'h0,          'h0,          0);
    add(0, 1, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 1, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    // PC wrap from 0xFFFF_FFFC to 0.
    add(1, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  0, 'h0,          0, 'h0,          'h0,          0);
    add(0, 1, 'hF000_0000,  0,  0, 'h0,        0, 'h0,          0,  1, 'h0,          0, 'h0,          'h0,          0);
    add(0, 0, 'h0,          1,  0, 'h0,        1, 'hFFFF_FFFC,  0,  0, 'h0,          1, 'hF000_0000,  'h0,          0);
    add(0, 1, 'hF000_FFFC,  0,  0, 'h0,        0, 'h0,          0,  1, 'hFFFF_FFFC,  0, 'hF000_0000,  'h0,          0);
    add(0, 0, 'h0,          1,  0, 'h0,        0, 'h0,          0,  0, 'hFFFF_FFFC,  1, 'hF000_FFFC,  'hFFFF_FFFC, 0);
    add(0, 0, 'h0,          0,  0, 'h0,        0, 'h0,          0,  1, 'h0,          0, 'hF000_FFFC,  'hFFFF_FFFC, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst              = vecs[i].rst;
      u_if.imem_ack    = vecs[i].ack;
      u_if.imem_rdata  = vecs[i].rdata;
      u_if.instr_ready = vecs[i].ready;
      u_if.br_taken    = vecs[i].br;
      u_if.br_target   = vecs[i].btgt;
      u_if.jmp         = vecs[i].jmp;
      u_if.jmp_target  = vecs[i].jtgt;
      u_if.halt        = vecs[i].halt;
      #1;
      n_vec++;
      if ({u_if.imem_req, u_if.imem_addr, u_if.instr_valid, u_if.instr, u_if.instr_pc,
           u_if.fetch_err} !== {vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].instr,
                                vecs[i].ipc, vecs[i].err}) begin
        n_err++;
        $display("FAIL vec%0d: got req=%b addr=%h vld=%b instr=%h pc=%h err=%b, want req=%b addr=%h vld=%b instr=%h pc=%h err=%b",
                 i, u_if.imem_req, u_if.imem_addr, u_if.instr_valid, u_if.instr,
                 u_if.instr_pc, u_if.fetch_err, vecs[i].req, vecs[i].addr, vecs[i].valid,
                 vecs[i].instr, vecs[i].ipc, vecs[i].err);
      end
      step();
    end

    // Throughput: ACK and READY always high give one instruction per 2 cycles.
    do_reset();
    u_if.imem_ack    = 1'b1;
    u_if.instr_ready = 1'b1;
    n_acc  = 0;
    exp_pc = 32'h0;
    for (int c = 0; c < 20; c++) begin
      u_if.imem_rdata = u_if.imem_addr ^ 32'hC0DE_0000;
      if (u_if.instr_valid) begin
        check32("stream_pc", u_if.instr_pc, exp_pc);
        check32("stream_instr", u_if.instr, exp_pc ^ 32'hC0DE_0000);
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      step();
    end
    check32("stream_count", n_acc, 32'd9);

    // HALT raised during FETCH: fetch completes and is delivered, then stop.
    do_reset();
    check32("halt_idle_req", {31'h0, u_if.imem_req}, 32'h0);
    step();
    u_if.halt = 1'b1;
    check32("halt_fetch_req0", {31'h0, u_if.imem_req}, 32'h1);
    step();
    check32("halt_fetch_req1", {31'h0, u_if.imem_req}, 32'h1);
    u_if.imem_ack   = 1'b1;
    u_if.imem_rdata = 32'h1234_5678;
    step();
    u_if.imem_ack = 1'b0;
    check32("halt_hold_valid", {31'h0, u_if.instr_valid}, 32'h1);
    check32("halt_hold_instr", u_if.instr, 32'h1234_5678);
    u_if.instr_ready = 1'b1;
    step();
    u_if.halt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      u_if.imem_ack = 1'b1;
      check32("halted_req_vld", {30'h0, u_if.imem_req, u_if.instr_valid}, 32'h0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
